// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: colour count, writer FSM states and the
// pixel-to-RAM address map that both the write and scan-out sides must agree on.
package fb_pkg;

  localparam int NB_COLORS = 3;

  typedef enum logic [0:0] {
    ST_WRITE     = 1'b0,
    ST_WAIT_SWAP = 1'b1
  } wr_state_t;

  // Linear bank address of one colour sample; color runs fastest, then angle, then row.
  function automatic logic [31:0] fb_addr(input logic [31:0] color,
                                          input logic [31:0] angle,
                                          input logic [31:0] row,
                                          input logic [31:0] nb_angles);
    return color + 32'(NB_COLORS) * angle + 32'(NB_COLORS) * nb_angles * row;
  endfunction

endpackage

// File: rtl/fb_pixel_counter.sv
// Colour/angle/row position of the incoming raster beat, with carry chain,
// synchronous clear and a load-zero override that re-aligns the beat to the frame origin.
module fb_pixel_counter
  import fb_pkg::*;
#(
  parameter int NB_ANGLES   = 128,
  parameter int NB_ROWS     = 32,
  parameter int ROW_WIDTH   = 5,
  parameter int ANGLE_WIDTH = $clog2(NB_ANGLES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   advance,
  input  logic                   clear,
  input  logic                   load_zero,
  output logic [1:0]             color,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic [ROW_WIDTH-1:0]   row,
  output logic                   last,
  output logic                   origin
);

  logic [1:0]             cnt_color, nxt_color;
  logic [ANGLE_WIDTH-1:0] cnt_angle, nxt_angle;
  logic [ROW_WIDTH-1:0]   cnt_row,   nxt_row;

  assign origin = (cnt_color == '0) && (cnt_angle == '0) && (cnt_row == '0);

  // color/angle/row describe the current beat; load_zero makes it the frame origin.
  always_comb begin
    color = load_zero ? '0 : cnt_color;
    angle = load_zero ? '0 : cnt_angle;
    row   = load_zero ? '0 : cnt_row;
    last  = (color == 2'(NB_COLORS - 1)) &&
            (angle == ANGLE_WIDTH'(NB_ANGLES - 1)) &&
            (row == ROW_WIDTH'(NB_ROWS - 1));
    nxt_color = color + 2'd1;
    nxt_angle = angle;
    nxt_row   = row;
    if (color == 2'(NB_COLORS - 1)) begin
      nxt_color = '0;
      if (angle == ANGLE_WIDTH'(NB_ANGLES - 1)) begin
        nxt_angle = '0;
        nxt_row   = (row == ROW_WIDTH'(NB_ROWS - 1)) ? '0 : row + ROW_WIDTH'(1);
      end else begin
        nxt_angle = angle + ANGLE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_color <= '0;
      cnt_angle <= '0;
      cnt_row   <= '0;
    end else if (clear) begin
      cnt_color <= '0;
      cnt_angle <= '0;
      cnt_row   <= '0;
    end else if (advance) begin
      cnt_color <= nxt_color;
      cnt_angle <= nxt_angle;
      cnt_row   <= nxt_row;
    end
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Write side of the double-buffered LED frame buffer: raster bytes -> RAM strobes
// into the bank not being scanned. Optional SOF re-alignment via FB_WRITER_SOF_RESYNC_EN.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int ROW_WIDTH  = 5,
  parameter int NB_ROWS    = 32,
  parameter int NB_ANGLES  = 128,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sof,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_bank,
  output logic                  swap_req,
  input  logic                  swap_ack,
  output logic                  frame_done
);

  localparam int ANGLE_WIDTH = $clog2(NB_ANGLES);

  if (NB_COLORS * NB_ANGLES * NB_ROWS > 2 ** ADDR_WIDTH) begin : g_addr_range_chk
    $error("frame_buffer_writer: frame does not fit in ADDR_WIDTH bits");
  end
  if (NB_ROWS > 2 ** ROW_WIDTH) begin : g_row_range_chk
    $error("frame_buffer_writer: NB_ROWS does not fit in ROW_WIDTH bits");
  end

  wr_state_t              state, next_state;
  logic                   accept, frame_end, bank_toggle, load_zero;
  logic [1:0]             beat_color;
  logic [ANGLE_WIDTH-1:0] beat_angle;
  logic [ROW_WIDTH-1:0]   beat_row;
  logic                   beat_last, cnt_origin;

  // s_ready is low during reset and in WAIT_SWAP, so accept implies WRITE.
  assign accept    = s_valid & s_ready;
  assign frame_end = accept & beat_last;

  fb_pixel_counter #(
    .NB_ANGLES  (NB_ANGLES),
    .NB_ROWS    (NB_ROWS),
    .ROW_WIDTH  (ROW_WIDTH),
    .ANGLE_WIDTH(ANGLE_WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .advance  (accept),
    .clear    (frame_end),
    .load_zero(load_zero),
    .color    (beat_color),
    .angle    (beat_angle),
    .row      (beat_row),
    .last     (beat_last),
    .origin   (cnt_origin)
  );

`ifdef FB_WRITER_SOF_RESYNC_EN
  logic [7:0] sof_err_cnt;

  assign load_zero = accept & s_sof;

  // Counts SOF markers that arrive somewhere other than the expected frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_err_cnt <= '0;
    end else if (load_zero && !cnt_origin && (sof_err_cnt != 8'hFF)) begin
      sof_err_cnt <= sof_err_cnt + 8'd1;
    end
  end
`else
  logic unused_cfg;

  assign load_zero  = 1'b0;
  assign unused_cfg = s_sof | cnt_origin;
`endif

  always_comb begin
    next_state  = state;
    bank_toggle = 1'b0;
    case (state)
      ST_WRITE: begin
        if (frame_end) next_state = ST_WAIT_SWAP;
      end
      ST_WAIT_SWAP: begin
        if (swap_ack) begin
          next_state  = ST_WRITE;
          bank_toggle = 1'b1;
        end
      end
    endcase
  end

  // Control stage: state, handshake and bank registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_WRITE;
      s_ready    <= 1'b0;
      swap_req   <= 1'b0;
      frame_done <= 1'b0;
      w_bank     <= 1'b0;
    end else begin
      state      <= next_state;
      s_ready    <= (next_state == ST_WRITE);
      swap_req   <= (next_state == ST_WAIT_SWAP);
      frame_done <= bank_toggle;
      w_bank     <= w_bank ^ bank_toggle;
    end
  end

  // Write stage: one cycle after the accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      w_en <= accept;
      if (accept) begin
        w_addr <= ADDR_WIDTH'(fb_addr(32'(beat_color), 32'(beat_angle),
                                      32'(beat_row), 32'(NB_ANGLES)));
        w_data <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer: randomized raster traffic against a
// linear beat-index model (address == position of the beat within its frame).
module tb_frame_buffer_writer;

  localparam int ADDR_WIDTH = 14;
  localparam int DATA_WIDTH = 8;
  localparam int NB_ROWS    = 32;
  localparam int NB_ANGLES  = 128;
  localparam int FRAME      = 3 * NB_ANGLES * NB_ROWS;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [DATA_WIDTH-1:0] s_data = '0;
  logic                  s_valid = 1'b0;
  logic                  s_sof = 1'b0;
  logic                  swap_ack = 1'b0;
  logic                  s_ready, w_en, w_bank, swap_req, frame_done;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic                  m_w_en, m_bank, m_swap, m_done, m_ready, m_wait;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_data;
  int                    m_idx;
  int                    m_err;

  frame_buffer_writer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .ROW_WIDTH (5),
    .NB_ROWS   (NB_ROWS),
    .NB_ANGLES (NB_ANGLES),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sof     (s_sof),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_bank    (w_bank),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_w_en = 1'b0; m_addr = '0; m_data = '0; m_bank = 1'b0;
    m_swap = 1'b0; m_done = 1'b0; m_ready = 1'b0; m_wait = 1'b0;
    m_idx = 0; m_err = 0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic cycle();
    logic acc, ack, sof, r;
    logic [DATA_WIDTH-1:0] d;
    int a;
    r = rst; acc = s_valid && m_ready && !rst; ack = swap_ack; sof = s_sof; d = s_data;
    @(posedge clk); #1;
    if (r) begin
      model_reset();
      return;
    end
    m_w_en = acc;
    m_done = 1'b0;
    if (m_wait) begin
      if (ack) begin
        m_wait = 1'b0;
        m_bank = ~m_bank;
        m_done = 1'b1;
      end
    end else if (acc) begin
      a = m_idx;
`ifdef FB_WRITER_SOF_RESYNC_EN
      if (sof) begin
        if (a != 0 && m_err < 255) m_err++;
        a = 0;
      end
`else
      if (sof) a = m_idx;
`endif
      m_addr = ADDR_WIDTH'(a);
      m_data = d;
      m_idx  = a + 1;
      if (a == FRAME - 1) begin
        m_wait = 1'b1;
        m_idx  = 0;
      end
    end
    m_swap  = m_wait;
    m_ready = !m_wait;
  endtask

  task automatic test_reset();
    s_valid = 1'b0; s_sof = 1'b0; swap_ack = 1'b0; s_data = '0;
    rst = 1'b1; #1;
    model_reset();
    repeat (3) cycle();
    checks++;
    if ({w_en, w_addr, w_data, w_bank, swap_req, frame_done, s_ready} !== '0) begin
      errors++;
      $display("FAIL reset_values: en/addr/data/bank/swap/done/ready=%h, expected 0",
               {w_en, w_addr, w_data, w_bank, swap_req, frame_done, s_ready});
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: s_ready=%b, expected 1", s_ready);
    end
  endtask

  task automatic test_first_beats();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'hA0 + i);
      cycle();
      checks++;
      if (w_en !== 1'b1 || w_addr !== 14'(i) || w_data !== 8'(8'hA0 + i)) begin
        errors++;
        $display("FAIL first_beats[%0d]: w_en=%b w_addr=%0d w_data=%h, expected 1 %0d %h",
                 i, w_en, w_addr, w_data, i, 8'(8'hA0 + i));
      end
    end
    s_valid = 1'b0;
    cycle();
    checks++;
    if (w_en !== 1'b0) begin
      errors++;
      $display("FAIL first_beats_idle: w_en=%b, expected 0", w_en);
    end
  endtask

  task automatic test_addr_387();
    bit seen = 0;
    for (int n = 0; n < 4000 && m_idx <= 387; n++) begin
      s_valid = ($urandom % 4) != 0;
      s_data  = 8'($urandom);
      cycle();
      checks++;
      if (w_en !== m_w_en || (m_w_en && (w_addr !== m_addr || w_data !== m_data))) begin
        errors++;
        $display("FAIL addr387_write: w_en=%b w_addr=%0d w_data=%h, expected %b %0d %h",
                 w_en, w_addr, w_data, m_w_en, m_addr, m_data);
      end
      checks++;
      if ({w_bank, swap_req, frame_done, s_ready} !== {m_bank, m_swap, m_done, m_ready}) begin
        errors++;
        $display("FAIL addr387_ctrl: bank/swap/done/ready=%b, expected %b",
                 {w_bank, swap_req, frame_done, s_ready}, {m_bank, m_swap, m_done, m_ready});
      end
      if (m_w_en && m_idx == 388) begin
        seen = 1;
        checks++;
        if (w_addr !== 14'(0 + 3 * 1 + 3 * NB_ANGLES * 1)) begin
          errors++;
          $display("FAIL addr387_map: w_addr=%0d, expected 387", w_addr);
        end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL addr387_reach: beat at color0/angle1/row1 not written, idx=%0d", m_idx);
    end
  endtask

  task automatic test_full_frame();
    int n = 0;
    s_valid = 1'b1;
    while (!m_wait && n < FRAME + 100) begin
      s_data = 8'($urandom);
      cycle();
      n++;
      checks++;
      if (w_en !== m_w_en || (m_w_en && (w_addr !== m_addr || w_data !== m_data))) begin
        errors++;
        $display("FAIL frame_write: w_en=%b w_addr=%0d w_data=%h, expected %b %0d %h",
                 w_en, w_addr, w_data, m_w_en, m_addr, m_data);
      end
      checks++;
      if ({w_bank, swap_req, frame_done, s_ready} !== {m_bank, m_swap, m_done, m_ready}) begin
        errors++;
        $display("FAIL frame_ctrl: bank/swap/done/ready=%b, expected %b",
                 {w_bank, swap_req, frame_done, s_ready}, {m_bank, m_swap, m_done, m_ready});
      end
    end
    checks++;
    if (w_en !== 1'b1 || w_addr !== 14'(FRAME - 1) || swap_req !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL frame_last: w_en=%b w_addr=%0d swap_req=%b s_ready=%b, expected 1 %0d 1 0",
               w_en, w_addr, swap_req, s_ready, FRAME - 1);
    end
    for (int i = 0; i < 10; i++) begin
      s_data = 8'($urandom);
      cycle();
      checks++;
      if (w_en !== 1'b0 || swap_req !== 1'b1 || s_ready !== 1'b0 || w_bank !== 1'b0) begin
        errors++;
        $display("FAIL frame_hold[%0d]: w_en=%b swap_req=%b s_ready=%b w_bank=%b, expected 0 1 0 0",
                 i, w_en, swap_req, s_ready, w_bank);
      end
    end
  endtask

  task automatic test_swap();
    swap_ack = 1'b1;
    s_data   = 8'h5C;
    cycle();
    swap_ack = 1'b0;
    checks++;
    if (w_bank !== 1'b1 || frame_done !== 1'b1 || s_ready !== 1'b1 || swap_req !== 1'b0 || w_en !== 1'b0) begin
      errors++;
      $display("FAIL swap_grant: bank=%b done=%b ready=%b swap_req=%b w_en=%b, expected 1 1 1 0 0",
               w_bank, frame_done, s_ready, swap_req, w_en);
    end
    cycle();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 14'd0 || w_data !== 8'h5C || frame_done !== 1'b0 || w_bank !== 1'b1) begin
      errors++;
      $display("FAIL swap_next_beat: w_en=%b addr=%0d data=%h done=%b bank=%b, expected 1 0 5c 0 1",
               w_en, w_addr, w_data, frame_done, w_bank);
    end
    checks++;
    if ({w_bank, swap_req, frame_done, s_ready} !== {m_bank, m_swap, m_done, m_ready}) begin
      errors++;
      $display("FAIL swap_model: bank/swap/done/ready=%b, expected %b",
               {w_bank, swap_req, frame_done, s_ready}, {m_bank, m_swap, m_done, m_ready});
    end
    s_valid = 1'b0;
  endtask

  task automatic test_ack_in_write_and_reset();
    for (int n = 0; n < 40; n++) begin
      s_valid  = ($urandom % 3) != 0;
      s_data   = 8'($urandom);
      swap_ack = 1'b1;
      cycle();
      checks++;
      if (w_en !== m_w_en || (m_w_en && (w_addr !== m_addr || w_data !== m_data))) begin
        errors++;
        $display("FAIL ack_write: w_en=%b w_addr=%0d w_data=%h, expected %b %0d %h",
                 w_en, w_addr, w_data, m_w_en, m_addr, m_data);
      end
      checks++;
      if (w_bank !== 1'b1 || frame_done !== 1'b0 || swap_req !== 1'b0 || s_ready !== 1'b1) begin
        errors++;
        $display("FAIL ack_ignored: bank=%b done=%b swap_req=%b ready=%b, expected 1 0 0 1",
                 w_bank, frame_done, swap_req, s_ready);
      end
    end
    swap_ack = 1'b0;
    s_valid  = 1'b1;
    rst = 1'b1;
    #2;
    model_reset();
    checks++;
    if ({w_en, w_addr, w_data, w_bank, swap_req, frame_done, s_ready} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: en/addr/data/bank/swap/done/ready=%h, expected 0",
               {w_en, w_addr, w_data, w_bank, swap_req, frame_done, s_ready});
    end
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    checks++;
    if (w_en !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rearm: w_en=%b s_ready=%b, expected 0 1", w_en, s_ready);
    end
    s_data = 8'h3E;
    cycle();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 14'd0 || w_data !== 8'h3E || w_bank !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_beat: w_en=%b addr=%0d data=%h bank=%b, expected 1 0 3e 0",
               w_en, w_addr, w_data, w_bank);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_random_traffic();
    for (int n = 0; n < 600; n++) begin
      s_valid  = ($urandom % 2) != 0;
      s_data   = 8'($urandom);
      swap_ack = ($urandom % 8) == 0;
      s_sof    = ($urandom % 16) == 0;
      cycle();
      checks++;
      if (w_en !== m_w_en || (m_w_en && (w_addr !== m_addr || w_data !== m_data))) begin
        errors++;
        $display("FAIL random_write: w_en=%b w_addr=%0d w_data=%h, expected %b %0d %h",
                 w_en, w_addr, w_data, m_w_en, m_addr, m_data);
      end
      checks++;
      if ({w_bank, swap_req, frame_done, s_ready} !== {m_bank, m_swap, m_done, m_ready}) begin
        errors++;
        $display("FAIL random_ctrl: bank/swap/done/ready=%b, expected %b",
                 {w_bank, swap_req, frame_done, s_ready}, {m_bank, m_swap, m_done, m_ready});
      end
    end
    s_valid = 1'b0; swap_ack = 1'b0; s_sof = 1'b0;
  endtask

`ifdef FB_WRITER_SOF_RESYNC_EN
  task automatic test_sof_resync();
    rst = 1'b1;
    #1;
    model_reset();
    cycle();
    rst = 1'b0;
    cycle();
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_sof   = (i == 5);
      s_data  = 8'(8'h10 + i);
      cycle();
      checks++;
      if (w_en !== 1'b1 || w_addr !== m_addr || w_data !== m_data) begin
        errors++;
        $display("FAIL sof_beat[%0d]: w_en=%b addr=%0d data=%h, expected 1 %0d %h",
                 i, w_en, w_addr, w_data, m_addr, m_data);
      end
    end
    s_sof = 1'b0;
    checks++;
    if (w_addr !== 14'd0 || dut.sof_err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL sof_realign: w_addr=%0d err_cnt=%0d, expected 0 1", w_addr, dut.sof_err_cnt);
    end
    s_data = 8'h77;
    cycle();
    checks++;
    if (w_en !== 1'b1 || w_addr !== 14'd1) begin
      errors++;
      $display("FAIL sof_continue: w_en=%b addr=%0d, expected 1 1", w_en, w_addr);
    end
    s_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_beats();
    test_addr_387();
    test_full_frame();
    test_swap();
    test_ack_in_write_and_reset();
    test_random_traffic();
`ifdef FB_WRITER_SOF_RESYNC_EN
    test_sof_resync();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
